// File: rtl/hit_lives_manager.sv
// Game-level state keeper: lives, BCD score, post-hit invulnerability and game flow.
// Optional HIT_LIVES_BONUS_EN: extra life each time the score thousands digit rolls up.
module hit_lives_manager #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_FRAMES = 60,
  parameter int OVER_FRAMES   = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        hit_pulse,
  input  logic        point_pulse,
  input  logic        start_key,
  output logic [2:0]  lives,
  output logic [15:0] score_bcd,
  output logic [1:0]  game_state,
  output logic        invuln_blink,
  output logic        life_lost
);

  // state     | meaning
  // IDLE      | waiting for start_key
  // PLAYING   | hits counted, points counted
  // COOLDOWN  | invulnerable for INVULN_FRAMES frames, blinking
  // GAME_OVER | lives exhausted, start accepted after OVER_FRAMES frames
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAYING   = 2'b01,
    COOLDOWN  = 2'b10,
    GAME_OVER = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blink_q, blink_d;
  logic        lost_q, lost_d;

  logic [7:0]  cnt_inc;
  logic        point_ok;
  logic        bonus;
  logic        cool_done;
  logic        over_done;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cnt_inc   = cnt_q + 8'd1;
  assign cool_done = startOfFrame && (cnt_inc == 8'(INVULN_FRAMES));
  assign over_done = start_key && (cnt_q == 8'(OVER_FRAMES));
  assign point_ok  = point_pulse && ((state_q == PLAYING) || (state_q == COOLDOWN))
                     && (score_q != 16'h9999);

`ifdef HIT_LIVES_BONUS_EN
  assign bonus = point_ok && (score_q[11:0] == 12'h999);
`else
  assign bonus = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lives_q <= 3'(START_LIVES);
      score_q <= 16'h0000;
      cnt_q   <= 8'd0;
      blink_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_key) state_d = PLAYING;
      PLAYING:   if (hit_pulse) state_d = (lives_q == 3'd1) ? GAME_OVER : COOLDOWN;
      COOLDOWN:  if (cool_done) state_d = PLAYING;
      GAME_OVER: if (over_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    lives_d = lives_q;
    score_d = point_ok ? bcd_inc(score_q) : score_q;
    cnt_d   = cnt_q;
    lost_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_key) begin
          lives_d = 3'(START_LIVES);
          score_d = 16'h0000;
          cnt_d   = 8'd0;
        end
      end
      PLAYING: begin
        cnt_d = 8'd0;
        if (hit_pulse) begin
          lost_d = 1'b1;
          // a terminal hit always ends the game, bonus or not
          if (lives_q == 3'd1)  lives_d = 3'd0;
          else if (!bonus)      lives_d = lives_q - 3'd1;
        end else if (bonus && (lives_q < 3'(MAX_LIVES))) begin
          lives_d = lives_q + 3'd1;
        end
      end
      COOLDOWN: begin
        if (bonus && (lives_q < 3'(MAX_LIVES))) lives_d = lives_q + 3'd1;
        if (startOfFrame) cnt_d = cool_done ? 8'd0 : cnt_inc;
      end
      GAME_OVER: begin
        if (over_done)                                        cnt_d = 8'd0;
        else if (startOfFrame && (cnt_q < 8'(OVER_FRAMES)))   cnt_d = cnt_inc;
      end
      default: ;
    endcase
    blink_d = (state_d == COOLDOWN) && cnt_d[2];
  end

  assign lives        = lives_q;
  assign score_bcd    = score_q;
  assign game_state   = state_q;
  assign invuln_blink = blink_q;
  assign life_lost    = lost_q;

endmodule

// File: tb/tb_hit_lives_manager.sv
// Bench for hit_lives_manager: directed scenarios plus random traffic against a
// plain-integer game model (lives, decimal score, frame count).
module tb_hit_lives_manager;
  localparam int START = 3;
  localparam int MAXL  = 7;
  localparam int INV   = 60;
  localparam int OVR   = 90;

  logic        clk = 1'b0;
  logic        reset, sof, hit, pt, sk;
  logic [2:0]  lives;
  logic [15:0] score_bcd;
  logic [1:0]  game_state;
  logic        invuln_blink, life_lost;

  int checks = 0;
  int errors = 0;

  int m_state, m_lives, m_score, m_frames, m_lost;

  hit_lives_manager #(
    .START_LIVES(START), .MAX_LIVES(MAXL), .INVULN_FRAMES(INV), .OVER_FRAMES(OVR)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hit_pulse(hit),
    .point_pulse(pt), .start_key(sk), .lives(lives), .score_bcd(score_bcd),
    .game_state(game_state), .invuln_blink(invuln_blink), .life_lost(life_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = START; m_score = 0; m_frames = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit p, input bit k);
    bit b;
    b = 0;
    m_lost = 0;
    if ((m_state == 1 || m_state == 2) && p && m_score < 9999) begin
      m_score++;
`ifdef HIT_LIVES_BONUS_EN
      if (m_score % 1000 == 0) b = 1;
`endif
    end
    case (m_state)
      0: if (k) begin m_state = 1; m_lives = START; m_score = 0; m_frames = 0; end
      1: begin
        if (h) begin
          m_lost = 1;
          m_frames = 0;
          if (m_lives == 1) begin m_lives = 0; m_state = 3; end
          else begin m_lives = m_lives - 1 + (b ? 1 : 0); m_state = 2; end
        end else if (b && m_lives < MAXL) m_lives++;
      end
      2: begin
        if (b && m_lives < MAXL) m_lives++;
        if (s) begin
          m_frames++;
          if (m_frames == INV) begin m_state = 1; m_frames = 0; end
        end
      end
      default: begin
        if (k && m_frames == OVR) begin m_state = 0; m_frames = 0; end
        else if (s && m_frames < OVR) m_frames++;
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("state", 32'(game_state), 32'(m_state));
    check_eq("lives", 32'(lives), 32'(m_lives));
    check_eq("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    check_eq("blink", 32'(invuln_blink), (m_state == 2) ? 32'((m_frames / 4) % 2) : 32'd0);
    check_eq("life_lost", 32'(life_lost), 32'(m_lost));
  endtask

  task automatic step(input bit s, input bit h, input bit p, input bit k);
    sof = s; hit = h; pt = p; sk = k;
    @(posedge clk);
    model_step(s, h, p, k);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    bit s, h, p, k, hit_in_frame;
    sof = 0; hit = 0; pt = 0; sk = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check_eq("rst_state", 32'(game_state), 32'd0);
    check_eq("rst_lives", 32'(lives), 32'd3);
    check_eq("rst_score", 32'(score_bcd), 32'h0);
    check_eq("rst_blink", 32'(invuln_blink), 32'd0);
    check_eq("rst_lost", 32'(life_lost), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // start, points, first hit, ignored hit in cooldown, blink run
    step(0, 0, 0, 1);
    check_eq("start_state", 32'(game_state), 32'd1);
    repeat (5) step(0, 0, 1, 0);
    check_eq("score5", 32'(score_bcd), 32'h0005);
    step(0, 1, 0, 0);
    check_eq("hit_lives", 32'(lives), 32'd2);
    check_eq("hit_lost", 32'(life_lost), 32'd1);
    check_eq("hit_state", 32'(game_state), 32'd2);
    for (int f = 0; f < 70; f++) begin
      step(1, (f == 10), 0, 0);
      step(0, 0, 0, 0);
    end
    check_eq("cool_exit", 32'(game_state), 32'd1);
    check_eq("cool_lives", 32'(lives), 32'd2);

    // simultaneous hit + point + frame, then exactly 60 frames of cooldown
    step(1, 1, 1, 0);
    check_eq("sim_lives", 32'(lives), 32'd1);
    check_eq("sim_score", 32'(score_bcd), 32'h0006);
    repeat (59) step(1, 0, 0, 0);
    check_eq("cool59", 32'(game_state), 32'd2);
    step(1, 0, 0, 0);
    check_eq("cool60", 32'(game_state), 32'd1);

    // terminal hit, early start ignored, late start accepted, held start
    step(0, 1, 1, 0);
    check_eq("over_state", 32'(game_state), 32'd3);
    check_eq("over_lives", 32'(lives), 32'd0);
    check_eq("over_score", 32'(score_bcd), 32'h0007);
    repeat (50) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check_eq("early_start", 32'(game_state), 32'd3);
    repeat (45) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check_eq("to_idle", 32'(game_state), 32'd0);
    step(0, 0, 0, 1);
    check_eq("restart_state", 32'(game_state), 32'd1);
    check_eq("restart_lives", 32'(lives), 32'd3);
    check_eq("restart_score", 32'(score_bcd), 32'h0);

    // score carry and saturation
    repeat (999) step(0, 0, 1, 0);
    check_eq("score999", 32'(score_bcd), 32'h0999);
    step(0, 0, 1, 0);
    check_eq("score1000", 32'(score_bcd), 32'h1000);
`ifdef HIT_LIVES_BONUS_EN
    check_eq("bonus_lives", 32'(lives), 32'd4);
`else
    check_eq("bonus_lives", 32'(lives), 32'd3);
`endif
    repeat (8999) step(0, 0, 1, 0);
    check_eq("score9999", 32'(score_bcd), 32'h9999);
    step(0, 0, 1, 0);
    check_eq("score_sat", 32'(score_bcd), 32'h9999);

    // async reset in cooldown with lives=1, score 0123
    do_reset();
    step(0, 0, 0, 1);
    repeat (123) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (60) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    check_eq("pre_rst_lives", 32'(lives), 32'd1);
    check_eq("pre_rst_score", 32'(score_bcd), 32'h0123);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_state", 32'(game_state), 32'd0);
    check_eq("arst_lives", 32'(lives), 32'd3);
    check_eq("arst_score", 32'(score_bcd), 32'h0);
    check_eq("arst_blink", 32'(invuln_blink), 32'd0);
    check_eq("arst_lost", 32'(life_lost), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // random traffic
    hit_in_frame = 0;
    for (int i = 0; i < 15000; i++) begin
      s = ($urandom_range(0, 3) == 0);
      h = !hit_in_frame && ($urandom_range(0, 99) == 0);
      p = ($urandom_range(0, 2) == 0);
      k = ($urandom_range(0, 15) == 0);
      hit_in_frame = s ? 1'b0 : (hit_in_frame | h);
      step(s, h, p, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
